// File: rtl/traffic_pkg.sv
// Shared encodings for the intersection phase scheduler: phase codes, road tags and lamp patterns.
package traffic_pkg;

  typedef enum logic [2:0] {
    ST_A_GRN = 3'd0,
    ST_A_YEL = 3'd1,
    ST_A_CLR = 3'd2,
    ST_B_GRN = 3'd3,
    ST_B_YEL = 3'd4,
    ST_B_CLR = 3'd5,
    ST_WALK  = 3'd6
  } state_t;

  typedef enum logic {
    ROAD_A = 1'b0,
    ROAD_B = 1'b1
  } road_t;

  // Lamp bus order is {A_R, A_Y, A_G, B_R, B_Y, B_G}
  localparam logic [5:0] LED_A_GRN   = 6'b001100;
  localparam logic [5:0] LED_A_YEL   = 6'b010100;
  localparam logic [5:0] LED_ALL_RED = 6'b100100;
  localparam logic [5:0] LED_B_GRN   = 6'b100001;
  localparam logic [5:0] LED_B_YEL   = 6'b100010;

  function automatic logic [5:0] led_of(input state_t s);
    case (s)
      ST_A_GRN: led_of = LED_A_GRN;
      ST_A_YEL: led_of = LED_A_YEL;
      ST_B_GRN: led_of = LED_B_GRN;
      ST_B_YEL: led_of = LED_B_YEL;
      default:  led_of = LED_ALL_RED;
    endcase
  endfunction

endpackage

// File: rtl/traffic_phase_arbiter_tick_prescaler.sv
// Divides the system clock down to a one-cycle tick every TICK_DIV cycles.
module tick_prescaler #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic CLK,
  input  logic RST,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count_reg;

  always_ff @(posedge CLK) begin
    if (RST) begin
      count_reg <= '0;
    end else if (count_reg == LAST) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign tick = (count_reg == LAST);

endmodule

// File: rtl/traffic_phase_arbiter.sv
// Two-road phase scheduler: green arbitration, yellow/all-red clearance, pedestrian walk, countdowns and lamps.
module traffic_phase_arbiter
  import traffic_pkg::*;
#(
  parameter int TICK_DIV  = 50_000_000,
  parameter int MIN_GREEN = 10,
  parameter int MAX_GREEN = 40,
  parameter int YELLOW    = 4,
  parameter int ALLRED    = 2,
  parameter int WALK      = 15
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       AS,
  input  logic       BS,
  input  logic       PED_REQ,
  output logic [2:0] state,
  output logic [5:0] A_time,
  output logic [5:0] B_time,
  output logic [5:0] led,
  output logic       walk,
  output logic       ped_ack
);

  logic       tick;
  state_t     state_reg, state_next;
  logic [5:0] elapsed_reg, elapsed_next;
  logic       ped_reg, ped_next;
  road_t      last_reg, last_next;

  logic [6:0] e_plus;
  logic       own_sensor, other_sensor, green_exit;
  logic [5:0] green_count, yellow_count;

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .CLK  (CLK),
    .RST  (RST),
    .tick (tick)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg   <= ST_A_GRN;
      elapsed_reg <= '0;
      ped_reg     <= 1'b0;
      last_reg    <= ROAD_A;
    end else begin
      state_reg   <= state_next;
      elapsed_reg <= elapsed_next;
      ped_reg     <= ped_next;
      last_reg    <= last_next;
    end
  end

  // Green exit is judged on the elapsed count as it will be after this tick
  assign e_plus       = {1'b0, elapsed_reg} + 7'd1;
  assign own_sensor   = (state_reg == ST_B_GRN) ? BS : AS;
  assign other_sensor = (state_reg == ST_B_GRN) ? AS : BS;
  assign green_exit   = tick && (e_plus >= 7'(MIN_GREEN)) && (other_sensor || ped_reg)
                        && (!own_sensor || (e_plus >= 7'(MAX_GREEN)));

  always_comb begin
    state_next = state_reg;
    last_next  = last_reg;
    case (state_reg)
      ST_A_GRN: if (green_exit) state_next = ST_A_YEL;
      ST_A_YEL: if (tick && elapsed_reg == 6'(YELLOW - 1)) state_next = ST_A_CLR;
      ST_A_CLR: if (tick && elapsed_reg == 6'(ALLRED - 1)) begin
        last_next  = ROAD_A;
        state_next = ped_reg ? ST_WALK : ST_B_GRN;
      end
      ST_B_GRN: if (green_exit) state_next = ST_B_YEL;
      ST_B_YEL: if (tick && elapsed_reg == 6'(YELLOW - 1)) state_next = ST_B_CLR;
      ST_B_CLR: if (tick && elapsed_reg == 6'(ALLRED - 1)) begin
        last_next  = ROAD_B;
        state_next = ped_reg ? ST_WALK : ST_A_GRN;
      end
      ST_WALK: if (tick && elapsed_reg == 6'(WALK - 1)) begin
        state_next = (last_reg == ROAD_A) ? ST_B_GRN : ST_A_GRN;
      end
      default: state_next = ST_A_GRN;
    endcase
  end

  always_comb begin
    elapsed_next = elapsed_reg;
    if (state_next != state_reg) begin
      elapsed_next = '0;
    end else if (tick && elapsed_reg != 6'd63) begin
      elapsed_next = elapsed_reg + 6'd1;
    end
  end

  // Entering WALK serves the request, even if the button is pressed in that same cycle
  assign ped_next = (state_next == ST_WALK && state_reg != ST_WALK) ? 1'b0 : (ped_reg | PED_REQ);

  assign green_count  = (elapsed_reg >= 6'(MAX_GREEN)) ? 6'd0 : 6'(MAX_GREEN) - elapsed_reg;
  assign yellow_count = 6'(YELLOW) - elapsed_reg;

  always_comb begin
    A_time = '0;
    B_time = '0;
    case (state_reg)
      ST_A_GRN: A_time = green_count;
      ST_A_YEL: A_time = yellow_count;
      ST_B_GRN: B_time = green_count;
      ST_B_YEL: B_time = yellow_count;
      default: ;
    endcase
  end

  assign state   = state_reg;
  assign led     = led_of(state_reg);
  assign walk    = (state_reg == ST_WALK);
  assign ped_ack = ped_reg;

endmodule
